// File: rtl/xbar_pkg.sv
// Shared types and round-robin pick helper for the stream crossbar scheduler.
// Exposes the per-master grant state and a wrap-around first-set search.
package xbar_pkg;

    typedef enum logic {IDLE, LOCK} grant_state_e;

    localparam int RR_MAX = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } rr_pick_t;

    // First set bit of req at or after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX-1:0] req,
        input int unsigned       ptr,
        input int unsigned       n
    );
        rr_pick_t    r;
        int unsigned k;
        r = '0;
        for (int unsigned o = 0; o < RR_MAX; o++) begin
            if (o < n) begin
                k = ptr + o;
                if (k >= n) k = k - n;
                if (!r.found && req[k]) begin
                    r.found = 1'b1;
                    r.idx   = 5'(k);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/xbar_rr_arbiter.sv
// One master port's round-robin grant FSM: pointer, owner id and lock.
// Ports: clk, rst, req (eligible slaves), done (owner's last beat taken), busy, id.
module xbar_rr_arbiter
    import xbar_pkg::*;
#(
    parameter int S_DATA_COUNT = 2,
    parameter int T_ID___WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [S_DATA_COUNT-1:0] req,
    input  logic                    done,
    output logic                    busy,
    output logic [T_ID___WIDTH-1:0] id
);

    grant_state_e            state;
    logic [T_ID___WIDTH-1:0] ptr;
    logic [T_ID___WIDTH-1:0] nxt;
    logic [T_ID___WIDTH-1:0] base;
    logic [S_DATA_COUNT-1:0] cand;
    rr_pick_t                pick;

    // On release the search restarts after the owner, owner excluded,
    // so a waiting competitor takes over without a bubble.
    always_comb begin
        nxt  = (32'(id) == S_DATA_COUNT - 1) ? '0 : id + 1'b1;
        cand = req;
        if (state == LOCK) cand[id] = 1'b0;
        base = (state == LOCK) ? nxt : ptr;
        pick = rr_pick(RR_MAX'(cand), 32'(base), 32'(S_DATA_COUNT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            id    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick.found) begin
                        state <= LOCK;
                        id    <= pick.idx[T_ID___WIDTH-1:0];
                    end
                end
                LOCK: begin
                    if (done) begin
                        ptr <= nxt;
                        if (pick.found) id <= pick.idx[T_ID___WIDTH-1:0];
                        else            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == LOCK);

endmodule

// File: rtl/xbar_grant_scheduler.sv
// Per-output packet scheduler: one RR arbiter per master, packet-granular locks.
// Ports: s_valid_i/s_dest_i/s_last_i/s_ready_o (slaves), m_ready_i/m_valid_o/m_id_o/m_busy_o (masters).
module xbar_grant_scheduler
    import xbar_pkg::*;
#(
    parameter  int S_DATA_COUNT = 2,
    parameter  int M_DATA_COUNT = 3,
    localparam int T_ID___WIDTH = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1,
    localparam int T_DEST_WIDTH = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [S_DATA_COUNT-1:0]              s_valid_i,
    input  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0] s_dest_i,
    input  logic [S_DATA_COUNT-1:0]              s_last_i,
    output logic [S_DATA_COUNT-1:0]              s_ready_o,
    input  logic [M_DATA_COUNT-1:0]              m_ready_i,
    output logic [M_DATA_COUNT-1:0]              m_valid_o,
    output logic [M_DATA_COUNT*T_ID___WIDTH-1:0] m_id_o,
    output logic [M_DATA_COUNT-1:0]              m_busy_o
);

    logic [T_DEST_WIDTH-1:0] dest_a [S_DATA_COUNT];
    logic [T_ID___WIDTH-1:0] id_a   [M_DATA_COUNT];
    logic [S_DATA_COUNT-1:0] req_m  [M_DATA_COUNT];
    logic [S_DATA_COUNT-1:0] in_range;
    logic [S_DATA_COUNT-1:0] owned;
    logic [S_DATA_COUNT-1:0] own_rdy;
    logic [M_DATA_COUNT-1:0] busy;
    logic [M_DATA_COUNT-1:0] done;

    always_comb begin
        owned     = '0;
        own_rdy   = '0;
        s_ready_o = '0;
        m_valid_o = '0;
        m_id_o    = '0;
        done      = '0;
        for (int i = 0; i < S_DATA_COUNT; i++) begin
            dest_a[i]   = s_dest_i[i*T_DEST_WIDTH +: T_DEST_WIDTH];
            in_range[i] = 32'(dest_a[i]) < M_DATA_COUNT;
        end
        for (int j = 0; j < M_DATA_COUNT; j++) begin
            m_id_o[j*T_ID___WIDTH +: T_ID___WIDTH] = id_a[j];
            for (int i = 0; i < S_DATA_COUNT; i++) begin
                if (busy[j] && id_a[j] == T_ID___WIDTH'(i)) begin
                    owned[i]   = 1'b1;
                    own_rdy[i] = m_ready_i[j];
                end
            end
            m_valid_o[j] = busy[j] & s_valid_i[id_a[j]];
            done[j]      = m_valid_o[j] & m_ready_i[j] & s_last_i[id_a[j]];
        end
        // Out-of-range destinations are sunk so the slave never stalls.
        for (int i = 0; i < S_DATA_COUNT; i++) begin
            s_ready_o[i] = owned[i] ? own_rdy[i] : ~in_range[i];
        end
        for (int j = 0; j < M_DATA_COUNT; j++) begin
            req_m[j] = '0;
            for (int i = 0; i < S_DATA_COUNT; i++) begin
                req_m[j][i] = s_valid_i[i] & ~owned[i]
                            & (dest_a[i] == T_DEST_WIDTH'(j));
            end
        end
    end

    for (genvar g = 0; g < M_DATA_COUNT; g++) begin : g_arb
        xbar_rr_arbiter #(
            .S_DATA_COUNT (S_DATA_COUNT),
            .T_ID___WIDTH (T_ID___WIDTH)
        ) u_arb (
            .clk  (clk),
            .rst  (rst),
            .req  (req_m[g]),
            .done (done[g]),
            .busy (busy[g]),
            .id   (id_a[g])
        );
    end

    assign m_busy_o = busy;

endmodule

// File: tb/tb_xbar_grant_scheduler.sv
// Directed bench for xbar_grant_scheduler with S=2, M=3.
// Each task drives one scenario and checks hand-computed values inline.
module tb_xbar_grant_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] s_valid;
    logic [3:0] s_dest;
    logic [1:0] s_last;
    logic [1:0] s_ready;
    logic [2:0] m_ready;
    logic [2:0] m_valid;
    logic [2:0] m_id;
    logic [2:0] m_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xbar_grant_scheduler #(
        .S_DATA_COUNT (2),
        .M_DATA_COUNT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid_i (s_valid),
        .s_dest_i  (s_dest),
        .s_last_i  (s_last),
        .s_ready_o (s_ready),
        .m_ready_i (m_ready),
        .m_valid_o (m_valid),
        .m_id_o    (m_id),
        .m_busy_o  (m_busy)
    );

    // Upstream rule: a slave's dest stays fixed for the whole packet.
    logic [1:0] in_pkt;
    logic [1:0] pd [2];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            in_pkt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s_valid[i] && s_ready[i]) begin
                    if (in_pkt[i] && s_dest[2*i +: 2] != pd[i])
                        $error("FAIL dest_stable slave %0d got %0d want %0d",
                               i, s_dest[2*i +: 2], pd[i]);
                    in_pkt[i] <= !s_last[i];
                    pd[i]     <= s_dest[2*i +: 2];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = '0; s_dest = '0; s_last = '0; m_ready = '0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (m_busy !== 3'b000) begin errors++; $display("FAIL reset_busy got %b want 000", m_busy); end
            checks++; if (m_valid !== 3'b000) begin errors++; $display("FAIL reset_mvalid got %b want 000", m_valid); end
            checks++; if (s_ready !== 2'b00) begin errors++; $display("FAIL reset_sready got %b want 00", s_ready); end
            checks++; if (m_id !== 3'b000) begin errors++; $display("FAIL reset_mid got %b want 000", m_id); end
        end
    endtask

    task automatic test_single_packet();
        m_ready = 3'b111; s_dest = 4'b0001; s_valid = 2'b01; s_last = 2'b00;
        #1;
        checks++; if (m_busy !== 3'b000) begin errors++; $display("FAIL single_pre_busy got %b want 000", m_busy); end
        checks++; if (s_ready !== 2'b00) begin errors++; $display("FAIL single_pre_sready got %b want 00", s_ready); end
        tick();
        checks++; if (m_busy !== 3'b010) begin errors++; $display("FAIL single_busy got %b want 010", m_busy); end
        checks++; if (m_id[1] !== 1'b0) begin errors++; $display("FAIL single_id got %b want 0", m_id[1]); end
        checks++; if (m_valid !== 3'b010) begin errors++; $display("FAIL single_mvalid got %b want 010", m_valid); end
        checks++; if (s_ready !== 2'b01) begin errors++; $display("FAIL single_sready got %b want 01", s_ready); end
        tick();
        tick();
        s_last = 2'b01;
        #1;
        checks++; if (m_busy !== 3'b010) begin errors++; $display("FAIL single_busy_last got %b want 010", m_busy); end
        tick();
        s_valid = 2'b00; s_last = 2'b00;
        #1;
        checks++; if (m_busy !== 3'b000) begin errors++; $display("FAIL single_release got %b want 000", m_busy); end
        checks++; if (m_valid !== 3'b000) begin errors++; $display("FAIL single_release_mvalid got %b want 000", m_valid); end
    endtask

    task automatic test_alternate();
        int own;
        m_ready = 3'b111; s_dest = 4'b1010; s_valid = 2'b11; s_last = 2'b00;
        #1;
        checks++; if (m_busy[2] !== 1'b0) begin errors++; $display("FAIL alt_pre_busy got %b want 0", m_busy[2]); end
        for (int k = 1; k <= 8; k++) begin
            tick();
            own = ((k - 1) / 2) % 2;
            s_last  = ((k - 1) % 2 == 1) ? 2'b11 : 2'b00;
            s_valid = (k == 8) ? 2'b10 : 2'b11;
            #1;
            checks++; if (m_busy[2] !== 1'b1) begin errors++; $display("FAIL alt_busy k=%0d got %b want 1", k, m_busy[2]); end
            checks++; if (m_id[2] !== own[0]) begin errors++; $display("FAIL alt_owner k=%0d got %b want %0d", k, m_id[2], own); end
            checks++; if (m_valid[2] !== 1'b1) begin errors++; $display("FAIL alt_mvalid k=%0d got %b want 1", k, m_valid[2]); end
            checks++; if (s_ready !== (own == 1 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_sready k=%0d got %b own %0d", k, s_ready, own); end
        end
        tick();
        s_valid = 2'b00; s_last = 2'b00;
        #1;
        checks++; if (m_busy !== 3'b000) begin errors++; $display("FAIL alt_release got %b want 000", m_busy); end
    endtask

    task automatic test_concurrent();
        m_ready = 3'b111; s_dest = 4'b1000; s_valid = 2'b11; s_last = 2'b00;
        #1;
        checks++; if (m_busy !== 3'b000) begin errors++; $display("FAIL conc_pre_busy got %b want 000", m_busy); end
        tick();
        checks++; if (m_busy !== 3'b101) begin errors++; $display("FAIL conc_busy got %b want 101", m_busy); end
        checks++; if (m_id !== 3'b100) begin errors++; $display("FAIL conc_id got %b want 100", m_id); end
        checks++; if (m_valid !== 3'b101) begin errors++; $display("FAIL conc_mvalid got %b want 101", m_valid); end
        checks++; if (s_ready !== 2'b11) begin errors++; $display("FAIL conc_sready got %b want 11", s_ready); end
        s_last = 2'b11;
        tick();
        s_valid = 2'b00; s_last = 2'b00;
        #1;
        checks++; if (m_busy !== 3'b000) begin errors++; $display("FAIL conc_release got %b want 000", m_busy); end
        checks++; if (m_id !== 3'b100) begin errors++; $display("FAIL conc_id_hold got %b want 100", m_id); end
    endtask

    task automatic test_backpressure();
        m_ready = 3'b111; s_dest = 4'b0101; s_valid = 2'b01; s_last = 2'b00;
        tick();
        s_valid = 2'b11;
        #1;
        checks++; if (m_busy !== 3'b010) begin errors++; $display("FAIL bp_busy got %b want 010", m_busy); end
        checks++; if (m_id[1] !== 1'b0) begin errors++; $display("FAIL bp_id got %b want 0", m_id[1]); end
        checks++; if (s_ready !== 2'b01) begin errors++; $display("FAIL bp_sready got %b want 01", s_ready); end
        tick();
        m_ready = 3'b101;
        #1;
        checks++; if (s_ready !== 2'b00) begin errors++; $display("FAIL bp_stall_sready got %b want 00", s_ready); end
        checks++; if (m_valid !== 3'b010) begin errors++; $display("FAIL bp_stall_mvalid got %b want 010", m_valid); end
        checks++; if (m_id[1] !== 1'b0) begin errors++; $display("FAIL bp_stall_id got %b want 0", m_id[1]); end
        tick();
        m_ready = 3'b111;
        #1;
        checks++; if (s_ready !== 2'b01) begin errors++; $display("FAIL bp_resume_sready got %b want 01", s_ready); end
        tick();
        s_last = 2'b01;
        #1;
        checks++; if (m_id[1] !== 1'b0) begin errors++; $display("FAIL bp_last_id got %b want 0", m_id[1]); end
        tick();
        s_valid = 2'b10; s_last = 2'b10;
        #1;
        checks++; if (m_busy !== 3'b010) begin errors++; $display("FAIL bp_handover_busy got %b want 010", m_busy); end
        checks++; if (m_id[1] !== 1'b1) begin errors++; $display("FAIL bp_handover_id got %b want 1", m_id[1]); end
        checks++; if (s_ready !== 2'b10) begin errors++; $display("FAIL bp_handover_sready got %b want 10", s_ready); end
        tick();
        s_valid = 2'b00; s_last = 2'b00;
        #1;
        checks++; if (m_busy !== 3'b000) begin errors++; $display("FAIL bp_release got %b want 000", m_busy); end
    endtask

    task automatic test_out_of_range();
        m_ready = 3'b111; s_dest = 4'b1100; s_valid = 2'b10; s_last = 2'b10;
        #1;
        checks++; if (s_ready !== 2'b10) begin errors++; $display("FAIL oor_sready got %b want 10", s_ready); end
        checks++; if (m_valid !== 3'b000) begin errors++; $display("FAIL oor_mvalid got %b want 000", m_valid); end
        tick();
        checks++; if (m_busy !== 3'b000) begin errors++; $display("FAIL oor_busy got %b want 000", m_busy); end
        checks++; if (m_valid !== 3'b000) begin errors++; $display("FAIL oor_mvalid2 got %b want 000", m_valid); end
        checks++; if (s_ready !== 2'b10) begin errors++; $display("FAIL oor_sready2 got %b want 10", s_ready); end
        s_valid = 2'b00; s_last = 2'b00; s_dest = 4'b0000;
    endtask

    task automatic test_reset_mid();
        m_ready = 3'b111; s_dest = 4'b0000; s_valid = 2'b01; s_last = 2'b00;
        tick();
        checks++; if (m_busy !== 3'b001) begin errors++; $display("FAIL rmid_busy got %b want 001", m_busy); end
        checks++; if (m_valid !== 3'b001) begin errors++; $display("FAIL rmid_mvalid got %b want 001", m_valid); end
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (m_busy !== 3'b000) begin errors++; $display("FAIL rmid_rst_busy got %b want 000", m_busy); end
        checks++; if (m_valid !== 3'b000) begin errors++; $display("FAIL rmid_rst_mvalid got %b want 000", m_valid); end
        checks++; if (s_ready !== 2'b00) begin errors++; $display("FAIL rmid_rst_sready got %b want 00", s_ready); end
        checks++; if (m_id !== 3'b000) begin errors++; $display("FAIL rmid_rst_id got %b want 000", m_id); end
        tick();
        rst = 1'b0; s_valid = 2'b00;
        tick();
        checks++; if (m_busy !== 3'b000) begin errors++; $display("FAIL rmid_after got %b want 000", m_busy); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_alternate();
        test_concurrent();
        test_backpressure();
        test_out_of_range();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
